// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_pkg
// Brief   : Shared types and constants for the data-memory responder.
// Revision: 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Fault codes reported in the DONE cycle
  localparam logic [1:0] FLT_NONE     = 2'd0;
  localparam logic [1:0] FLT_MISALIGN = 2'd1;
  localparam logic [1:0] FLT_RANGE    = 2'd2;
  localparam logic [1:0] FLT_CONFLICT = 2'd3;

  // Latency counter width (latencies up to 15)
  localparam int CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module  : dmem_array
// Brief   : Single-port synchronous word RAM, read-first, no reset.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_array #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  logic [DATA_W-1:0] rdata_q;

  // Storage write and registered read of the addressed word
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder
// Brief   : MEM-stage data-memory slave with fixed access latency, pipeline
//           stall and fault reporting.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter int                DEPTH_LOG2 = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter int                RD_LAT     = 2,
  parameter int                WR_LAT     = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [ADDR_W-1:0] i_MEM_mem_DmemAddr,
  input  logic [DATA_W-1:0] i_MEM_mem_DmemDataW,
  input  logic              i_MEM_mem_MemRead,
  input  logic              i_MEM_mem_MemWrite,
  output logic [DATA_W-1:0] o_MEM_mem_DmemDataR,
  output logic              o_MEM_mem_Stall,
  output logic              o_MEM_mem_Fault,
  output logic [1:0]        o_MEM_mem_FaultCode,
  output logic [ADDR_W-1:0] o_MEM_mem_FaultAddr
);

  localparam logic [CNT_W-1:0] RD_LAT_M1 = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LAT_M1 = CNT_W'(WR_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [1:0]        code_q, code_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;

  logic              idle, req, enter_done, ram_we, out_of_range, done_rd_ok;
  logic [ADDR_W-1:0] cur_addr, cur_off;
  logic [DATA_W-1:0] cur_wdata, ram_rdata;
  logic              cur_wr;
  logic [1:0]        cur_code, acc_code;
  logic [CNT_W-1:0]  lat_m1;

  assign idle = (state_q == IDLE);
  assign req  = i_MEM_mem_MemRead | i_MEM_mem_MemWrite;

  // In IDLE the live request drives the array so a 1-cycle latency works;
  // afterwards the registered request is used.
  assign cur_addr  = idle ? i_MEM_mem_DmemAddr  : addr_q;
  assign cur_wdata = idle ? i_MEM_mem_DmemDataW : wdata_q;
  assign cur_wr    = idle ? (i_MEM_mem_MemWrite & ~i_MEM_mem_MemRead) : wr_q;
  assign cur_code  = idle ? acc_code : code_q;
  assign cur_off   = cur_addr - BASE_ADDR;

  // Offsets below BASE_ADDR wrap to large values and land out of range
  if (DEPTH_LOG2 + 2 < ADDR_W) begin : g_range_chk
    assign out_of_range = |cur_off[ADDR_W-1:DEPTH_LOG2+2];
  end else begin : g_range_full
    assign out_of_range = 1'b0;
  end

  // Fault classification at acceptance: conflict > misaligned > out of range
  always_comb begin
    acc_code = FLT_NONE;
    if (i_MEM_mem_MemRead && i_MEM_mem_MemWrite) begin
      acc_code = FLT_CONFLICT;
    end else if (|cur_off[1:0]) begin
      acc_code = FLT_MISALIGN;
    end else if (out_of_range) begin
      acc_code = FLT_RANGE;
    end
  end

  // Next-state, counter and datapath register updates
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    code_d       = code_q;
    data_d       = data_q;
    fault_addr_d = fault_addr_q;
    enter_done   = 1'b0;
    ram_we       = 1'b0;
    lat_m1       = cur_wr ? WR_LAT_M1 : RD_LAT_M1;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = i_MEM_mem_DmemAddr;
          wdata_d = i_MEM_mem_DmemDataW;
          wr_d    = cur_wr;
          code_d  = acc_code;
          cnt_d   = lat_m1;
          if (lat_m1 == '0) begin
            enter_done = 1'b1;
          end else begin
            state_d = cur_wr ? WR_WAIT : RD_WAIT;
          end
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        // Keep the read result visible until the next read completes
        if (!wr_q && code_q == FLT_NONE) begin
          data_d = ram_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_done) begin
      state_d = DONE;
      cnt_d   = '0;
      ram_we  = cur_wr && (cur_code == FLT_NONE);
      if (cur_code != FLT_NONE) begin
        fault_addr_d = cur_addr;
        if (!cur_wr) begin
          data_d = '0;
        end
      end
    end
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      code_q       <= FLT_NONE;
      data_q       <= '0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
      code_q       <= code_d;
      data_q       <= data_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  dmem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (cur_off[DEPTH_LOG2+1:2]),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  // The array output holds the read word in DONE; it is shown directly then
  assign done_rd_ok = (state_q == DONE) && !wr_q && (code_q == FLT_NONE);

  assign o_MEM_mem_DmemDataR = done_rd_ok ? ram_rdata : data_q;
  assign o_MEM_mem_Stall     = nrst & ((idle & req) | (state_q == RD_WAIT) |
                                       (state_q == WR_WAIT));
  assign o_MEM_mem_Fault     = (state_q == DONE) && (code_q != FLT_NONE);
  assign o_MEM_mem_FaultCode = (state_q == DONE) ? code_q : FLT_NONE;
  assign o_MEM_mem_FaultAddr = fault_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_responder
// Brief   : Self-checking bench for dmem_responder (two latency configs).
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst_a, nrst_b, sel;
  logic        req_rd, req_wr;
  logic [31:0] req_addr, req_wdata;

  logic [31:0] data_a, data_b, faddr_a, faddr_b;
  logic        stall_a, stall_b, fault_a, fault_b;
  logic [1:0]  code_a, code_b;

  logic [31:0] data, faddr;
  logic        stall, fault;
  logic [1:0]  code;

  assign data  = sel ? data_b  : data_a;
  assign faddr = sel ? faddr_b : faddr_a;
  assign stall = sel ? stall_b : stall_a;
  assign fault = sel ? fault_b : fault_a;
  assign code  = sel ? code_b  : code_a;

  dmem_responder #(.RD_LAT(2), .WR_LAT(1)) u_dut_a (
    .clk                 (clk),
    .nrst                (nrst_a),
    .i_MEM_mem_DmemAddr  (req_addr),
    .i_MEM_mem_DmemDataW (req_wdata),
    .i_MEM_mem_MemRead   (req_rd & ~sel),
    .i_MEM_mem_MemWrite  (req_wr & ~sel),
    .o_MEM_mem_DmemDataR (data_a),
    .o_MEM_mem_Stall     (stall_a),
    .o_MEM_mem_Fault     (fault_a),
    .o_MEM_mem_FaultCode (code_a),
    .o_MEM_mem_FaultAddr (faddr_a)
  );

  dmem_responder #(.RD_LAT(2), .WR_LAT(3)) u_dut_b (
    .clk                 (clk),
    .nrst                (nrst_b),
    .i_MEM_mem_DmemAddr  (req_addr),
    .i_MEM_mem_DmemDataW (req_wdata),
    .i_MEM_mem_MemRead   (req_rd & sel),
    .i_MEM_mem_MemWrite  (req_wr & sel),
    .o_MEM_mem_DmemDataR (data_b),
    .o_MEM_mem_Stall     (stall_b),
    .o_MEM_mem_Fault     (fault_b),
    .o_MEM_mem_FaultCode (code_b),
    .o_MEM_mem_FaultAddr (faddr_b)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic [1:0]  exp_code;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    logic [1:0]  code;
    logic [31:0] faddr;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] faddr_model [2];
  vec_t        vecs [18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_stall"}, {63'd0, stall}, 64'd0);
    check({tag, "_data"},  {32'd0, data},  64'd0);
    check({tag, "_fault"}, {63'd0, fault}, 64'd0);
    check({tag, "_code"},  {62'd0, code},  64'd0);
    check({tag, "_faddr"}, {32'd0, faddr}, 64'd0);
  endtask

  // Drive one request, queue its expectation, wait for DONE and compare
  task automatic do_req(input vec_t v);
    exp_t e;
    int   cyc;
    bit   done;
    bit   quiet;
    @(posedge clk); #1;
    req_rd = v.rd; req_wr = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    e.data  = v.exp_data;
    e.code  = v.exp_code;
    e.fault = (v.exp_code != FLT_NONE);
    if (e.fault) faddr_model[sel] = v.addr;
    e.faddr = faddr_model[sel];
    e.lat   = (v.wr && !v.rd) ? (sel ? 3 : 1) : 2;
    sb.push_back(e);
    #1;
    check("stall_at_accept", {63'd0, stall}, 64'd1);
    cyc = 1; done = 1'b0; quiet = 1'b1;
    while (!done && cyc < 40) begin
      if (fault || code != FLT_NONE) quiet = 1'b0;
      @(posedge clk); #1;
      if (stall) cyc++;
      else done = 1'b1;
    end
    e = sb.pop_front();
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: stall still 1 after %0d cycles, required %0d", cyc, e.lat);
      return;
    end
    check("stall_cycles", 64'(cyc), 64'(e.lat));
    check("quiet_while_stalled", {63'd0, quiet}, 64'd1);
    check("rdata", {32'd0, data}, {32'd0, e.data});
    check("fault", {63'd0, fault}, {63'd0, e.fault});
    check("fault_code", {62'd0, code}, {62'd0, e.code});
    check("fault_addr", {32'd0, faddr}, {32'd0, e.faddr});
  endtask

  task automatic clear_req();
    req_rd = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rd    wr    addr          wdata         exp_data      code
    vecs = '{
      '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, FLT_NONE},
      '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, FLT_NONE},
      '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_0000, FLT_MISALIGN},
      '{1'b0, 1'b1, 32'h0000_0000, 32'h1,         32'h0000_0000, FLT_NONE},
      '{1'b0, 1'b1, 32'h0000_0004, 32'h2,         32'h0000_0000, FLT_NONE},
      '{1'b0, 1'b1, 32'h0000_0008, 32'h3,         32'h0000_0000, FLT_NONE},
      '{1'b0, 1'b1, 32'h0000_1000, 32'hBAD,       32'h0000_0000, FLT_RANGE},
      '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0001, FLT_NONE},
      '{1'b1, 1'b1, 32'h0000_0004, 32'h99,        32'h0000_0000, FLT_CONFLICT},
      '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         32'h0000_0002, FLT_NONE},
      '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0001, FLT_NONE},
      '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         32'h0000_0002, FLT_NONE},
      '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h0000_0003, FLT_NONE},
      '{1'b0, 1'b1, 32'h0000_0001, 32'hAA,        32'h0000_0003, FLT_MISALIGN},
      '{1'b0, 1'b1, 32'h0000_0FFC, 32'h55,        32'h0000_0003, FLT_NONE},
      '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         32'h0000_0055, FLT_NONE},
      '{1'b1, 1'b0, 32'h0000_1001, 32'h0,         32'h0000_0000, FLT_MISALIGN},
      '{1'b1, 1'b1, 32'h0000_1003, 32'h7,         32'h0000_0000, FLT_CONFLICT}
    };

    sel = 1'b0;
    clear_req();
    nrst_a = 1'b0; nrst_b = 1'b0;
    faddr_model[0] = '0; faddr_model[1] = '0;

    // Reset state, then release mid-cycle
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("in_reset");
    @(negedge clk);
    nrst_a = 1'b1; nrst_b = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("after_reset");

    // Table of transactions on the RD_LAT=2 / WR_LAT=1 instance
    for (int i = 0; i < 18; i++) begin
      do_req(vecs[i]);
    end
    @(posedge clk); #1;
    clear_req();

    // WR_LAT=3 instance: seed word 0x20 with 0x5
    sel = 1'b1;
    do_req('{1'b0, 1'b1, 32'h20, 32'h5, 32'h0, FLT_NONE});

    // Abort a write in WR_WAIT with reset
    @(posedge clk); #1;
    req_wr = 1'b1; req_rd = 1'b0; req_addr = 32'h20; req_wdata = 32'h77;
    #1;
    check("abort_wr_accept_stall", {63'd0, stall}, 64'd1);
    @(posedge clk); #1;
    check("abort_wr_wait_stall", {63'd0, stall}, 64'd1);
    nrst_b = 1'b0;
    #1;
    check("abort_wr_stall_drop", {63'd0, stall}, 64'd0);
    check("abort_wr_fault", {63'd0, fault}, 64'd0);
    check("abort_wr_code", {62'd0, code}, 64'd0);
    @(posedge clk); #1;
    clear_req();
    @(negedge clk);
    nrst_b = 1'b1;
    faddr_model[1] = '0;
    do_req('{1'b1, 1'b0, 32'h20, 32'h0, 32'h5, FLT_NONE});

    // Abort a read in RD_WAIT with reset
    @(posedge clk); #1;
    req_rd = 1'b1; req_wr = 1'b0; req_addr = 32'h20;
    @(posedge clk); #1;
    check("abort_rd_wait_stall", {63'd0, stall}, 64'd1);
    nrst_b = 1'b0;
    #1;
    check_idle_outputs("abort_rd");
    @(posedge clk); #1;
    clear_req();
    @(negedge clk);
    nrst_b = 1'b1;
    faddr_model[1] = '0;
    do_req('{1'b1, 1'b0, 32'h20, 32'h0, 32'h5, FLT_NONE});
    @(posedge clk); #1;
    clear_req();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory slave answering the MEM-stage data-memory port: address, write data, MemRead, MemWrite in; read data out.
- Holds a word-addressed on-chip array and applies a fixed, parameterised access latency.
- Back-pressures the pipeline with a stall while an access is in flight.
- Reports illegal accesses through a fault code and a captured fault address.

Parameters:
- DATA_W, 32, data word width
- ADDR_W, 32, byte address width
- DEPTH_LOG2, 10, log2 of array depth in words (1024 words = 4 KiB)
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned
- RD_LAT, 2, read stall cycles; legal range 1..15
- WR_LAT, 1, write stall cycles; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- nrst  in  1  asynchronous active-low reset
- i_MEM_mem_DmemAddr  in  ADDR_W  byte address
- i_MEM_mem_DmemDataW  in  DATA_W  write data
- i_MEM_mem_MemRead  in  1  read request
- i_MEM_mem_MemWrite  in  1  write request
- o_MEM_mem_DmemDataR  out  DATA_W  read data, valid in the DONE cycle
- o_MEM_mem_Stall  out  1  pipeline must hold the MEM stage and its request inputs
- o_MEM_mem_Fault  out  1  one-cycle pulse in the DONE cycle of a faulting access
- o_MEM_mem_FaultCode  out  2  0 none, 1 misaligned, 2 out of range, 3 read+write conflict
- o_MEM_mem_FaultAddr  out  ADDR_W  address of the most recent faulting access

Behaviour:
- Reset is asynchronous and active-low:
  - the FSM goes to IDLE; the latency counter clears
  - DmemDataR, Fault, FaultCode and FaultAddr all reset to 0
  - array contents are not reset
- FSM states are IDLE, RD_WAIT, WR_WAIT, DONE.
- IDLE:
  - MemRead or MemWrite high at cycle T accepts the request
  - Stall=1 combinationally in cycle T; address, data and op are registered
  - next state is RD_WAIT, or WR_WAIT for a write-only request
- The latency counter loads LAT-1; Stall=1 in every wait cycle.
- For RD_LAT=N, Stall is high in cycles T..T+N-1 and DONE is cycle T+N. WR_LAT works the same way.
- DONE:
  - Stall=0; DmemDataR holds the registered read result
  - the pipeline advances at the end of this cycle; next state is always IDLE
  - the request is therefore re-sampled no earlier than T+LAT+1, so one accepted request gives exactly one array access
- Write commit happens on the edge from the last WR_WAIT cycle into DONE.
- Read data is captured into DmemDataR on the edge into DONE. DmemDataR holds its value until the next read's DONE; writes do not change it.
- Fault checks run in IDLE at acceptance, with priority conflict > misaligned > out of range:
  - conflict: MemRead and MemWrite both high
  - misaligned: Addr[1:0] != 0
  - out of range: Addr-BASE_ADDR >= 4<<DEPTH_LOG2, unsigned; addresses below BASE_ADDR wrap and fault
- A faulting access:
  - still runs the full latency (RD_LAT for reads and conflicts, WR_LAT for writes)
  - does not touch the array; a faulting read returns DmemDataR=0
  - pulses Fault=1 and presents FaultCode in the DONE cycle
  - loads FaultAddr on the edge into DONE
- FaultCode is 0 in all non-DONE cycles.
- Read-after-write to the same address in consecutive requests returns the new data, because the commit precedes the next acceptance.
- Reset in RD_WAIT or WR_WAIT aborts the access: nothing is written, no fault is reported, and Stall drops immediately.
- Request deasserted while Stall=1 violates the protocol; the registered request completes unchanged.

Decomposition:
- dmem_pkg holds the state enum (IDLE/RD_WAIT/WR_WAIT/DONE), the FaultCode localparams (FLT_NONE, FLT_MISALIGN, FLT_RANGE, FLT_CONFLICT) and the latency-counter width (4).
- dmem_array is one sub-module: a single-port synchronous RAM with parameters DATA_W and DEPTH_LOG2, and ports clk, we, addr, wdata, rdata.
- The responder instantiates dmem_array and owns the FSM, the counter, fault detection and output registers.

Test Plan:
- Reset, no request: all outputs 0 and Stall=0; deassert nrst mid-cycle and outputs stay 0.
- RD_LAT=2, WR_LAT=1:
  - write 0x10 with 0xDEADBEEF: Stall for 1 cycle, DONE with Fault=0
  - then read 0x10: Stall for 2 cycles, DONE with DmemDataR=0xDEADBEEF
- Read 0x13: Stall for 2 cycles; DONE with DmemDataR=0, Fault=1, FaultCode=1, FaultAddr=0x13.
- Out of range and conflict:
  - write 0x1000 (DEPTH_LOG2=10): FaultCode=2, FaultAddr=0x1000; a later read of 0x0 returns its prior value
  - MemRead=MemWrite=1 at 0x4: FaultCode=3, and word 0x4 is unchanged
- Back-to-back reads of 0x0, 0x4, 0x8 (preloaded 1, 2, 3): each takes 3 cycles with DONE values 1, 2, 3, and exactly three array reads occur.
- Abort on reset:
  - assert nrst low in WR_WAIT of a write to 0x20 (old value 0x5), with WR_LAT=3: a later read returns 0x5 and Fault stays 0
  - repeat during RD_WAIT: FSM returns to IDLE and Stall=0 immediately
